// File: rtl/seg_bcd_capture_pkg.sv
// seg_cap_pkg: segment patterns, result codes and FSM states for seg_bcd_capture.
// SEG_CAP_DP_EN widens the captured segment field to include the decimal point.
package seg_cap_pkg;
  localparam logic [6:0] PAT_0 = 7'h40;
  localparam logic [6:0] PAT_1 = 7'h79;
  localparam logic [6:0] PAT_2 = 7'h24;
  localparam logic [6:0] PAT_3 = 7'h30;
  localparam logic [6:0] PAT_4 = 7'h19;
  localparam logic [6:0] PAT_5 = 7'h12;
  localparam logic [6:0] PAT_6 = 7'h02;
  localparam logic [6:0] PAT_7 = 7'h78;
  localparam logic [6:0] PAT_8 = 7'h00;
  localparam logic [6:0] PAT_9 = 7'h10;
  localparam logic [6:0] PAT_BLANK = 7'h7F;
  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_BAD = 4'hE;
`ifdef SEG_CAP_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  typedef enum logic [1:0] {WAIT, CAPT, HOLD} state_t;
endpackage

// File: rtl/seg_bcd_capture_if.sv
// seg_bcd_capture_if: display-bus pins plus capture results, named from the capture block's side.
interface seg_bcd_capture_if #(parameter int DIGITS = 4);
  logic [7:0]          i_segment;
  logic [DIGITS-1:0]   i_dig_sel_n;
  logic                i_clr;
  logic [4*DIGITS-1:0] o_bcd_out;
  logic [DIGITS-1:0]   o_dp_out;
  logic [DIGITS-1:0]   o_invalid;
  logic                o_frame_valid;
  logic                o_sel_err;
  modport master (
    output i_segment, i_dig_sel_n, i_clr,
    input  o_bcd_out, o_dp_out, o_invalid, o_frame_valid, o_sel_err
  );
  modport slave (
    input  i_segment, i_dig_sel_n, i_clr,
    output o_bcd_out, o_dp_out, o_invalid, o_frame_valid, o_sel_err
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: maps an active-low a..g pattern to a BCD digit, blank code or bad code.
module seg_pattern_decode
  import seg_cap_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_bcd,
  output logic       o_bad
);
  always_comb begin
    o_bcd = CODE_BAD;
    o_bad = 1'b0;
    case (i_pat)
      PAT_0:     o_bcd = 4'd0;
      PAT_1:     o_bcd = 4'd1;
      PAT_2:     o_bcd = 4'd2;
      PAT_3:     o_bcd = 4'd3;
      PAT_4:     o_bcd = 4'd4;
      PAT_5:     o_bcd = 4'd5;
      PAT_6:     o_bcd = 4'd6;
      PAT_7:     o_bcd = 4'd7;
      PAT_8:     o_bcd = 4'd8;
      PAT_9:     o_bcd = 4'd9;
      PAT_BLANK: o_bcd = CODE_BLANK;
      default:   o_bad = 1'b1;
    endcase
  end
endmodule

// File: rtl/seg_bcd_capture.sv
// seg_bcd_capture: debounced capture of a multiplexed active-low 7-segment bus into BCD frames.
// Define SEG_CAP_DP_EN to capture the decimal point; otherwise dp is ignored entirely.
module seg_bcd_capture
  import seg_cap_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int STABLE_CYC = 4,
  localparam int CNT_W = $clog2(STABLE_CYC + 1)
) (
  input logic clk,
  input logic rst_n,
  seg_bcd_capture_if.slave bus
);
  localparam int SW = SEG_W + DIGITS;
  logic [SW-1:0]       r_s1, r_s2, r_prev;
  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_miss;
  logic [4*DIGITS-1:0] r_bcd;
  logic [DIGITS-1:0]   r_dp, r_invalid, r_seen;
  logic                r_frame, r_sel_err;
  logic [SW-1:0]       w_pins;
  logic [SEG_W-1:0]    w_seg;
  logic [DIGITS-1:0]   w_sel, w_upd, w_seen_set;
  logic                w_chg, w_go, w_cap, w_multi, w_full, w_dp, w_bad;
  logic [3:0]          w_bcd;
  assign w_pins = {bus.i_segment[SEG_W-1:0], bus.i_dig_sel_n};
  assign w_chg  = r_s2 != r_prev;
  assign w_go   = !w_chg && r_cnt == CNT_W'(STABLE_CYC - 2);
  // A change that lands during CAPT is remembered so HOLD still leaves.
  always_comb begin
    w_state_nxt = r_state == WAIT ? (w_go ? CAPT : WAIT) :
                  r_state == CAPT ? HOLD :
                  (w_chg || r_miss) ? WAIT : HOLD;
    w_cnt_nxt = (r_state == WAIT && !w_chg && !w_go) ? r_cnt + 1'b1 : '0;
  end
  // Capture from prev: it always holds the value that was stable on entry to CAPT.
  assign w_seg      = r_prev[SW-1:DIGITS];
  assign w_sel      = ~r_prev[DIGITS-1:0];
  assign w_cap      = r_state == CAPT;
  assign w_multi    = |(w_sel & (w_sel - 1'b1));
  assign w_upd      = (w_cap && !w_multi) ? w_sel : '0;
  assign w_seen_set = r_seen | w_upd;
  assign w_full     = (&w_seen_set) && (|w_upd);
`ifdef SEG_CAP_DP_EN
  assign w_dp = ~w_seg[7];
`else
  assign w_dp = 1'b0;
`endif
  seg_pattern_decode u_dec (
    .i_pat (w_seg[6:0]),
    .o_bcd (w_bcd),
    .o_bad (w_bad)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= '1;
      r_s2      <= '1;
      r_prev    <= '1;
      r_state   <= WAIT;
      r_cnt     <= '0;
      r_miss    <= 1'b0;
      r_bcd     <= '1;
      r_dp      <= '0;
      r_invalid <= '0;
      r_seen    <= '0;
      r_frame   <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_s1      <= w_pins;
      r_s2      <= r_s1;
      r_prev    <= r_s2;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_miss    <= w_cap && w_chg;
      for (int k = 0; k < DIGITS; k++) begin
        if (w_upd[k]) begin
          r_bcd[4*k +: 4] <= w_bcd;
          r_dp[k]         <= w_dp;
        end
      end
      r_invalid <= bus.i_clr ? '0 : (r_invalid & ~w_upd) | (w_bad ? w_upd : '0);
      r_sel_err <= !bus.i_clr && (r_sel_err || (w_cap && w_multi));
      r_seen    <= (bus.i_clr || w_full) ? '0 : w_seen_set;
      r_frame   <= !bus.i_clr && w_full;
    end
  end
  assign bus.o_bcd_out     = r_bcd;
  assign bus.o_dp_out      = r_dp;
  assign bus.o_invalid     = r_invalid;
  assign bus.o_frame_valid = r_frame;
  assign bus.o_sel_err     = r_sel_err;
endmodule
